alu_regfile_wb: RTL

Register file and write-back scoreboard for the 4-bit datapath. It supplies the two source operands (Rd1, Rd2) to the ALU function units (AND/OR/NOR/...) and accepts their results back as write-backs. It tracks in-flight destinations so a dependent instruction is not issued until its operands are written or bypassed. It sits between the decode/issue stage and the ALU units.

---
 rtl/alu_pkg.sv | 9 +
 rtl/alu_scoreboard.sv | 58 +++++
 rtl/alu_regfile_wb.sv | 54 +++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: datapath widths and index/data types shared by the register file and the function units
package alu_pkg;
    localparam int DATA_W   = 4;
    localparam int NUM_REGS = 4;
    localparam int ADDR_W   = $clog2(NUM_REGS);
    localparam int CNT_W    = $clog2(NUM_REGS + 1);
    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/alu_scoreboard.sv
// alu_scoreboard: pending-write tracking, hazard detection and write-back error flag
//   in : clk, rst_n, iss_valid, iss_rs1, iss_rs2, iss_rd, wb_valid, wb_rd
//   out: iss_ready (no RAW/WAW hazard), pend_cnt (popcount of pending), wb_err (registered)
module alu_scoreboard #(
    parameter int NUM_REGS = alu_pkg::NUM_REGS,
    parameter int ADDR_W   = alu_pkg::ADDR_W,
    parameter int CNT_W    = $clog2(NUM_REGS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_rs1,
    input  logic [ADDR_W-1:0] iss_rs2,
    input  logic [ADDR_W-1:0] iss_rd,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_rd,
    output logic              iss_ready,
    output logic [CNT_W-1:0]  pend_cnt,
    output logic              wb_err
);
    logic [NUM_REGS-1:0] pend_q, pend_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                haz_rs1, haz_rs2, haz_rd, fire, dec;

    // a write-back landing this cycle resolves the hazard on its index
    assign haz_rs1   = pend_q[iss_rs1] && !(wb_valid && wb_rd == iss_rs1);
    assign haz_rs2   = pend_q[iss_rs2] && !(wb_valid && wb_rd == iss_rs2);
    assign haz_rd    = pend_q[iss_rd]  && !(wb_valid && wb_rd == iss_rd);
    assign iss_ready = !(haz_rs1 || haz_rs2 || haz_rd);
    assign fire      = iss_valid && iss_ready;
    assign dec       = wb_valid && pend_q[wb_rd];

    // issue is applied after the write-back clear so it wins on a shared index;
    // a fire always targets a bit that is clear or being cleared, so +fire -dec stays exact
    always_comb begin
        pend_d = pend_q;
        if (wb_valid) pend_d[wb_rd] = 1'b0;
        if (fire) pend_d[iss_rd] = 1'b1;
        cnt_d = cnt_q + CNT_W'(fire) - CNT_W'(dec);
        err_d = wb_valid && !pend_q[wb_rd];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign pend_cnt = cnt_q;
    assign wb_err   = err_q;
endmodule

// File: rtl/alu_regfile_wb.sv
// alu_regfile_wb: register file with write-back bypass and issue scoreboard
//   issue : iss_valid, iss_rs1, iss_rs2, iss_rd -> iss_ready, Rd1, Rd2 (bypassed operands)
//   wb    : wb_valid, wb_rd, wb_data (always accepted)
//   status: pend_cnt (pending writes), wb_err (previous write-back hit a non-pending register)
module alu_regfile_wb #(
    parameter int DATA_W   = alu_pkg::DATA_W,
    parameter int NUM_REGS = alu_pkg::NUM_REGS,
    parameter int ADDR_W   = alu_pkg::ADDR_W
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           iss_valid,
    input  logic [ADDR_W-1:0]              iss_rs1,
    input  logic [ADDR_W-1:0]              iss_rs2,
    input  logic [ADDR_W-1:0]              iss_rd,
    output logic                           iss_ready,
    output logic [DATA_W-1:0]              Rd1,
    output logic [DATA_W-1:0]              Rd2,
    input  logic                           wb_valid,
    input  logic [ADDR_W-1:0]              wb_rd,
    input  logic [DATA_W-1:0]              wb_data,
    output logic [$clog2(NUM_REGS+1)-1:0]  pend_cnt,
    output logic                           wb_err
);
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        if (wb_valid) regs_d[wb_rd] = wb_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) regs_q <= '{default: '0};
        else        regs_q <= regs_d;
    end

    assign Rd1 = (wb_valid && wb_rd == iss_rs1) ? wb_data : regs_q[iss_rs1];
    assign Rd2 = (wb_valid && wb_rd == iss_rs2) ? wb_data : regs_q[iss_rs2];

    alu_scoreboard #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .iss_valid (iss_valid),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .iss_rd    (iss_rd),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .iss_ready (iss_ready),
        .pend_cnt  (pend_cnt),
        .wb_err    (wb_err)
    );
endmodule
